// File: rtl/xsleena_sdr_arbiter.sv
// Round-robin arbiter of toggle-handshake ROM read channels onto one SDRAM read port,
// with a one-word last-fetch cache per channel.
module xsleena_sdr_arbiter #(
  parameter int unsigned NCH = 5,
  parameter int unsigned AW  = 25,
  parameter int unsigned DW  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH-1:0]    ch_req,
  output logic [NCH-1:0]    ch_rdy,
  output logic [NCH*DW-1:0] ch_dout,
  input  logic              inv,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic              mem_valid,
  input  logic [DW-1:0]     mem_din
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   gnt_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   tag_q   [NCH];
  logic [DW-1:0]   cache_q [NCH];
  logic [NCH-1:0]  valid_q;

  logic [NCH-1:0]  pending_c;
  logic [PW-1:0]   gnt_c;
  logic            any_c;
  logic [AW-1:0]   gnt_addr_c;
  logic            hit_c;
  logic            fill_c;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (int'(p) >= int'(NCH) - 1) return '0;
    return p + PW'(1);
  endfunction

  assign pending_c = ch_req ^ ch_rdy;

  // First pending channel at or after rr_ptr, wrapping to channel 0.
  always_comb begin
    int idx;
    gnt_c = '0;
    any_c = 1'b0;
    idx   = 0;
    for (int k = 0; k < int'(NCH); k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= int'(NCH)) idx = idx - int'(NCH);
      if (!any_c && pending_c[idx]) begin
        gnt_c = PW'(idx);
        any_c = 1'b1;
      end
    end
  end

  assign gnt_addr_c = ch_addr[int'(gnt_c)*int'(AW) +: AW];
  assign hit_c      = valid_q[gnt_c] && (tag_q[gnt_c] == gnt_addr_c);
  assign fill_c     = ((state_q == S_ISSUE) && mem_ack && mem_valid) ||
                      ((state_q == S_WAIT) && mem_valid);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      valid_q  <= '0;
      ch_rdy   <= '0;
      ch_dout  <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) begin
        tag_q[i]   <= '0;
        cache_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_c) begin
            if (hit_c) begin
              ch_dout[int'(gnt_c)*int'(DW) +: DW] <= cache_q[gnt_c];
              ch_rdy[gnt_c]                       <= ~ch_rdy[gnt_c];
              rr_ptr_q                            <= next_ptr(gnt_c);
            end else begin
              gnt_q    <= gnt_c;
              addr_q   <= gnt_addr_c;
              mem_addr <= gnt_addr_c;
              mem_rd   <= 1'b1;
              state_q  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ack) begin
            mem_rd  <= 1'b0;
            state_q <= mem_valid ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_valid) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Memory data completes the latched channel and refills its cache entry.
      if (fill_c) begin
        ch_dout[int'(gnt_q)*int'(DW) +: DW] <= mem_din;
        ch_rdy[gnt_q]                       <= ~ch_rdy[gnt_q];
        tag_q[gnt_q]                        <= addr_q;
        cache_q[gnt_q]                      <= mem_din;
        valid_q[gnt_q]                      <= 1'b1;
        rr_ptr_q                            <= next_ptr(gnt_q);
      end

      // Invalidate overrides a same-edge refill: data is delivered but not kept.
      if (inv) valid_q <= '0;
    end
  end

endmodule

// File: tb/tb_xsleena_sdr_arbiter.sv
// Directed bench for xsleena_sdr_arbiter: reset, miss/hit/invalidate, round-robin order,
// ack+valid collapse and reset during an outstanding read.
module tb_xsleena_sdr_arbiter;

  localparam int NCH = 5;
  localparam int AW  = 25;
  localparam int DW  = 16;

  logic              CLK;
  logic              RST;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_rdy;
  logic [NCH*DW-1:0] ch_dout;
  logic              inv;
  logic [AW-1:0]     mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic              mem_valid;
  logic [DW-1:0]     mem_din;

  int unsigned       n_cmp;
  int unsigned       n_err;
  logic [NCH-1:0]    exp_rdy;

  xsleena_sdr_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ch_addr   (ch_addr),
    .ch_req    (ch_req),
    .ch_rdy    (ch_rdy),
    .ch_dout   (ch_dout),
    .inv       (inv),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ack   (mem_ack),
    .mem_valid (mem_valid),
    .mem_din   (mem_din)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dout_of(input int ch);
    return ch_dout[ch*DW +: DW];
  endfunction

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    ch_addr[ch*AW +: AW] = a;
  endtask

  // Wait (bounded) for a read, check its address, answer with ack+valid together.
  task automatic serve(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (mem_rd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("serve_wait_ch%0d", ch), 32'(n < 20), 32'd1);
    chk($sformatf("serve_addr_ch%0d", ch), 32'(mem_addr), 32'(a));
    mem_ack = 1'b1; mem_valid = 1'b1; mem_din = d;
    tick();
    mem_ack = 1'b0; mem_valid = 1'b0;
    exp_rdy[ch] = ~exp_rdy[ch];
    chk($sformatf("serve_rdy_ch%0d", ch), 32'(ch_rdy), 32'(exp_rdy));
    chk($sformatf("serve_dout_ch%0d", ch), 32'(dout_of(ch)), 32'(d));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_rdy = '0;
    RST = 1'b1; ch_addr = '0; ch_req = '0; inv = 1'b0;
    mem_ack = 1'b0; mem_valid = 1'b0; mem_din = '0;

    // 1: reset and quiet idle
    tick(); tick();
    RST = 1'b0;
    chk("rst_rdy", 32'(ch_rdy), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_dout_or", 32'(|ch_dout), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_mem_rd", 32'(mem_rd), 32'd0);
    end

    // 2: single miss on ch3, ack then later valid
    set_addr(3, 25'h01234);
    ch_req[3] = 1'b1;
    tick();
    chk("miss_mem_rd", 32'(mem_rd), 32'd1);
    chk("miss_mem_addr", 32'(mem_addr), 32'h01234);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wait_mem_rd", 32'(mem_rd), 32'd0);
    chk("wait_rdy", 32'(ch_rdy), 32'd0);
    tick(); tick();
    mem_valid = 1'b1; mem_din = 16'hBEEF;
    tick();
    mem_valid = 1'b0;
    exp_rdy[3] = 1'b1;
    chk("miss_rdy", 32'(ch_rdy), 32'(exp_rdy));
    chk("miss_dout", 32'(dout_of(3)), 32'hBEEF);
    tick();
    chk("miss_rdy_once", 32'(ch_rdy), 32'(exp_rdy));

    // 3: hit, then invalidate, then fill suppressed by same-edge inv
    ch_req[3] = 1'b0;
    tick();
    exp_rdy[3] = 1'b0;
    chk("hit_rdy", 32'(ch_rdy), 32'(exp_rdy));
    chk("hit_dout", 32'(dout_of(3)), 32'hBEEF);
    chk("hit_mem_rd", 32'(mem_rd), 32'd0);
    inv = 1'b1;
    tick();
    inv = 1'b0;
    ch_req[3] = 1'b1;
    tick();
    chk("inv_miss_rd", 32'(mem_rd), 32'd1);
    chk("inv_miss_addr", 32'(mem_addr), 32'h01234);
    mem_ack = 1'b1; mem_valid = 1'b1; mem_din = 16'hCAFE; inv = 1'b1;
    tick();
    mem_ack = 1'b0; mem_valid = 1'b0; inv = 1'b0;
    exp_rdy[3] = 1'b1;
    chk("invfill_rdy", 32'(ch_rdy), 32'(exp_rdy));
    chk("invfill_dout", 32'(dout_of(3)), 32'hCAFE);
    ch_req[3] = 1'b0;
    tick();
    chk("invfill_miss", 32'(mem_rd), 32'd1);
    serve(3, 25'h01234, 16'hD00D);
    ch_req[3] = 1'b1;
    tick();
    exp_rdy[3] = 1'b1;
    chk("rehit_rdy", 32'(ch_rdy), 32'(exp_rdy));
    chk("rehit_dout", 32'(dout_of(3)), 32'hD00D);
    chk("rehit_mem_rd", 32'(mem_rd), 32'd0);

    // 4: fairness from rr_ptr=0 after reset
    RST = 1'b1; ch_req = '0;
    tick(); tick();
    RST = 1'b0; exp_rdy = '0;
    for (int i = 0; i < NCH; i++) set_addr(i, 25'(32'h100 + i));
    ch_req = 5'h1F;
    for (int i = 0; i < NCH; i++) serve(i, 25'(32'h100 + i), 16'(32'h1000 + i));
    set_addr(0, 25'h200);
    set_addr(4, 25'h204);
    ch_req[0] = 1'b0; ch_req[4] = 1'b0;
    serve(0, 25'h200, 16'h2000);
    serve(4, 25'h204, 16'h2004);

    // 5: ack+valid together completes from ISSUE; next grant on the following edge
    set_addr(1, 25'h300);
    set_addr(2, 25'h302);
    ch_req[1] = 1'b0; ch_req[2] = 1'b0;
    tick();
    chk("av_rd1", 32'(mem_rd), 32'd1);
    chk("av_addr1", 32'(mem_addr), 32'h300);
    mem_ack = 1'b1; mem_valid = 1'b1; mem_din = 16'h5A5A;
    tick();
    mem_ack = 1'b0; mem_valid = 1'b0;
    exp_rdy[1] = ~exp_rdy[1];
    chk("av_rdy", 32'(ch_rdy), 32'(exp_rdy));
    chk("av_dout", 32'(dout_of(1)), 32'h5A5A);
    chk("av_rd_low", 32'(mem_rd), 32'd0);
    tick();
    chk("av_next_rd", 32'(mem_rd), 32'd1);
    chk("av_next_addr", 32'(mem_addr), 32'h302);
    serve(2, 25'h302, 16'h2222);

    // 6: reset while waiting for data on ch1; late data is ignored
    set_addr(1, 25'h400);
    ch_req[1] = ~exp_rdy[1];
    tick();
    chk("rw_rd", 32'(mem_rd), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rw_wait", 32'(mem_rd), 32'd0);
    RST = 1'b1; ch_req = '0;
    tick(); tick();
    RST = 1'b0; exp_rdy = '0;
    mem_valid = 1'b1; mem_din = 16'h1111;
    tick();
    mem_valid = 1'b0;
    tick();
    chk("rw_rdy", 32'(ch_rdy), 32'd0);
    chk("rw_dout1", 32'(dout_of(1)), 32'd0);
    chk("rw_dout_or", 32'(|ch_dout), 32'd0);
    chk("rw_mem_rd", 32'(mem_rd), 32'd0);
    set_addr(1, 25'h300);
    ch_req[1] = 1'b1;
    tick();
    chk("rw_cache_cleared", 32'(mem_rd), 32'd1);
    serve(1, 25'h300, 16'h7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
